// File: rtl/npu_quant_pkg.sv
// Shared widths, zero-point constants and saturating accumulate helper
// for the requantization datapath.
package npu_quant_pkg;

  localparam int ACC_W  = 32;
  localparam int PROD_W = 64;
  localparam logic [7:0] QZP = 8'd128;
  localparam int QMIN = 0;
  localparam int QMAX = 255;

  // Signed add that pins to the 32-bit range instead of wrapping.
  function automatic logic signed [ACC_W-1:0] sat32(
    input logic signed [ACC_W-1:0] a,
    input logic signed [ACC_W-1:0] b
  );
    logic [ACC_W:0] s;
    s = {a[ACC_W-1], a} + {b[ACC_W-1], b};
    if (s[ACC_W] != s[ACC_W-1])
      sat32 = s[ACC_W] ? 32'sh8000_0000 : 32'sh7FFF_FFFF;
    else
      sat32 = s[ACC_W-1:0];
  endfunction

endpackage

// File: rtl/requant_round_clamp.sv
// Combinational requant tail: round-half-up arithmetic shift of the
// 64-bit product, add the 128 zero point and clamp to the uint8 range.
module requant_round_clamp
  import npu_quant_pkg::*;
#(
  parameter int SHIFT_W = 6
) (
  input  logic signed [PROD_W-1:0] prod,
  input  logic [SHIFT_W-1:0]       shift,
  input  logic                     relu,
  output logic [7:0]               q
);

  logic signed [PROD_W:0] ext;
  logic signed [PROD_W:0] rnd;
  logic signed [PROD_W:0] r;
  logic signed [PROD_W:0] biased;
  logic signed [PROD_W:0] lo;
  logic signed [PROD_W:0] hi;

  // One extra bit of headroom keeps the rounding add from overflowing.
  always_comb begin
    ext    = {prod[PROD_W-1], prod};
    rnd    = '0;
    if (shift != '0)
      rnd = 65'sd1 <<< (shift - SHIFT_W'(1));
    r      = (ext + rnd) >>> shift;
    biased = r + $signed({57'd0, QZP});
    lo     = relu ? $signed({57'd0, QZP}) : 65'(QMIN);
    hi     = 65'(QMAX);
    if (biased > hi)
      q = 8'(QMAX);
    else if (biased < lo)
      q = lo[7:0];
    else
      q = biased[7:0];
  end

endmodule

// File: rtl/psum_requant.sv
// Accumulates groups of PE partial sums and requantizes each group to a
// zero-point-128 uint8 activation behind a valid/ready output.
module psum_requant
  import npu_quant_pkg::*;
#(
  parameter int LEN_W   = 8,
  parameter int SHIFT_W = 6
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic signed [ACC_W-1:0]  in_opsum,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [LEN_W-1:0]         cfg_acc_len,
  input  logic signed [ACC_W-1:0]  cfg_mult,
  input  logic [SHIFT_W-1:0]       cfg_shift,
  input  logic                     cfg_relu,
  output logic [7:0]               out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     busy
);

  logic                     en;
  logic                     accept;
  logic                     last;
  logic [LEN_W-1:0]         cnt;
  logic [LEN_W-1:0]         len_q;
  logic [LEN_W-1:0]         eff_len;
  logic signed [ACC_W-1:0]  acc;
  logic signed [ACC_W-1:0]  mult_q;
  logic [SHIFT_W-1:0]       shift_q;
  logic                     relu_q;
  logic                     a_valid;
  logic signed [PROD_W-1:0] prod_d;
  logic signed [PROD_W-1:0] prod;
  logic [SHIFT_W-1:0]       b_shift;
  logic                     b_relu;
  logic                     b_valid;
  logic [7:0]               q;

  // The whole pipeline moves as one; a stalled output freezes every stage.
  assign en       = ~out_valid | out_ready;
  assign in_ready = en;
  assign accept   = in_valid & en;
  assign busy     = (cnt != '0) | a_valid | b_valid | out_valid;

  // The first beat of a group sees the live config; later beats use the captured length.
  always_comb begin
    eff_len = len_q;
    if (cnt == '0)
      eff_len = (cfg_acc_len == '0) ? LEN_W'(1) : cfg_acc_len;
    last = (cnt == eff_len - LEN_W'(1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      acc     <= '0;
      a_valid <= 1'b0;
      len_q   <= '0;
      mult_q  <= '0;
      shift_q <= '0;
      relu_q  <= 1'b0;
    end else if (en) begin
      a_valid <= accept & last;
      if (accept) begin
        if (cnt == '0) begin
          acc     <= in_opsum;
          len_q   <= eff_len;
          mult_q  <= cfg_mult;
          shift_q <= cfg_shift;
          relu_q  <= cfg_relu;
        end else begin
          acc <= sat32(acc, in_opsum);
        end
        cnt <= last ? '0 : cnt + LEN_W'(1);
      end
    end
  end

  // Config registers still hold this group's values when stage B samples them.
  assign prod_d = $signed({{(PROD_W-ACC_W){acc[ACC_W-1]}}, acc})
                * $signed({{(PROD_W-ACC_W){mult_q[ACC_W-1]}}, mult_q});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prod    <= '0;
      b_shift <= '0;
      b_relu  <= 1'b0;
      b_valid <= 1'b0;
    end else if (en) begin
      b_valid <= a_valid;
      if (a_valid) begin
        prod    <= prod_d;
        b_shift <= shift_q;
        b_relu  <= relu_q;
      end
    end
  end

  requant_round_clamp #(
    .SHIFT_W (SHIFT_W)
  ) u_round_clamp (
    .prod  (prod),
    .shift (b_shift),
    .relu  (b_relu),
    .q     (q)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (en) begin
      out_valid <= b_valid;
      if (b_valid)
        out_data <= q;
    end
  end

endmodule

// File: tb/tb_psum_requant.sv
// Scoreboard bench for psum_requant: directed groups push expected bytes,
// a negedge monitor pops and compares every output handshake.
module tb_psum_requant;

  localparam int LEN_W   = 8;
  localparam int SHIFT_W = 6;

  logic               clk = 1'b0;
  logic               rst;
  logic signed [31:0] in_opsum;
  logic               in_valid;
  logic               in_ready;
  logic [LEN_W-1:0]   cfg_acc_len;
  logic signed [31:0] cfg_mult;
  logic [SHIFT_W-1:0] cfg_shift;
  logic               cfg_relu;
  logic [7:0]         out_data;
  logic               out_valid;
  logic               out_ready;
  logic               busy;

  int checks = 0;
  int errors = 0;
  logic [7:0] expq[$];

  always #5 clk = ~clk;

  psum_requant #(
    .LEN_W   (LEN_W),
    .SHIFT_W (SHIFT_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_opsum    (in_opsum),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .cfg_acc_len (cfg_acc_len),
    .cfg_mult    (cfg_mult),
    .cfg_shift   (cfg_shift),
    .cfg_relu    (cfg_relu),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .busy        (busy)
  );

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Drives one beat and returns 1 time unit after the edge that accepted it.
  task automatic applyStimulus(input logic signed [31:0] v);
    bit done = 0;
    in_opsum = v;
    in_valid = 1'b1;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (in_ready) done = 1;
      @(posedge clk);
      #1;
    end
    if (!done) checkOutput("accept_timeout", 0, 1);
  endtask

  task automatic setCfg(input int len, input int mult, input int shift, input bit relu);
    cfg_acc_len = LEN_W'(len);
    cfg_mult    = mult;
    cfg_shift   = SHIFT_W'(shift);
    cfg_relu    = relu;
  endtask

  task automatic drain();
    int n = 0;
    while ((expq.size() != 0 || busy) && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput("drain_empty", 64'(expq.size()), 0);
    checkOutput("drain_idle", busy, 0);
  endtask

  // Monitor: pops on every handshake and checks data holds while stalled.
  initial begin
    bit stalled = 0;
    logic [7:0] held = '0;
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (rst) begin
        stalled = 0;
      end else begin
        if (stalled) begin
          checkOutput("stall_valid", out_valid, 1);
          checkOutput("stall_data", out_data, held);
        end
        if (out_valid && out_ready) begin
          if (expq.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_output: got %0d, expected no output", out_data);
          end else begin
            e = expq.pop_front();
            checkOutput("out_data", out_data, e);
          end
        end
        stalled = out_valid && !out_ready;
        held    = out_data;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1;
    in_opsum = '0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    setCfg(1, 1, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_out_data", out_data, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_in_ready", in_ready, 1);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Latency: two edges from acceptance to out_valid.
    setCfg(1, 1, 0, 0);
    expq.push_back(8'd133);
    applyStimulus(5);
    in_valid = 1'b0;
    checkOutput("lat_e0", out_valid, 0);
    @(posedge clk); #1;
    checkOutput("lat_e1", out_valid, 0);
    @(posedge clk); #1;
    checkOutput("lat_e2", out_valid, 1);
    drain();

    // Nine-beat group: 90*3 = 270, (270+2)>>2 = 68, +128 = 196.
    setCfg(9, 3, 2, 0);
    expq.push_back(8'd196);
    for (int i = 0; i < 9; i++) applyStimulus(10);
    in_valid = 1'b0;
    drain();

    // Clamp and rounding corners, single-beat groups.
    setCfg(1, 1, 0, 0);
    expq.push_back(8'd0);   applyStimulus(-500);
    expq.push_back(8'd255); applyStimulus(1000);
    setCfg(1, 1, 0, 1);
    expq.push_back(8'd128); applyStimulus(-3);
    setCfg(1, 1, 2, 0);
    expq.push_back(8'd127); applyStimulus(-6);
    in_valid = 1'b0;
    drain();

    // Accumulator saturation in both directions.
    setCfg(2, 1, 31, 0);
    expq.push_back(8'd129);
    applyStimulus(32'sh7FFF_FFF0);
    applyStimulus(32'sh7FFF_FFF0);
    setCfg(2, -1, 31, 0);
    expq.push_back(8'd129);
    applyStimulus(-32'sh7FFF_FFF0);
    applyStimulus(-32'sh7FFF_FFF0);
    in_valid = 1'b0;
    drain();

    // Backpressure on a back-to-back single-beat stream.
    setCfg(1, 1, 0, 0);
    for (int i = 1; i <= 8; i++) expq.push_back(8'(128 + i));
    fork
      begin
        for (int i = 1; i <= 8; i++) applyStimulus(i);
        in_valid = 1'b0;
      end
      begin
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (5) begin
          @(negedge clk);
          checkOutput("stall_in_ready", in_ready, 0);
          @(posedge clk);
        end
        #1 out_ready = 1'b1;
      end
    join
    drain();

    // Reset discards a partial group.
    setCfg(9, 1, 0, 0);
    for (int i = 0; i < 4; i++) applyStimulus(7);
    in_valid = 1'b0;
    checkOutput("pre_rst_busy", busy, 1);
    rst = 1'b1;
    #2;
    checkOutput("mid_rst_busy", busy, 0);
    checkOutput("mid_rst_out_valid", out_valid, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    expq.push_back(8'd137);
    for (int i = 0; i < 9; i++) applyStimulus(1);
    in_valid = 1'b0;
    drain();
    repeat (10) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
